// File: rtl/mavg_filter_bank.sv
`default_nettype none
// ============================================================================
// Module   : mavg_filter_bank
// Purpose  : Multi-channel power-of-two boxcar filter bank sharing one ring RAM;
//            emits low-pass, group-delay-aligned reference and saturated high-pass.
// Revision : 1.0 - initial release
// ============================================================================
module mavg_filter_bank #(
    parameter int DATA_WIDTH    = 16,
    parameter int NUM_CH        = 2,
    parameter int MAX_TAPS_LOG2 = 7
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             sample_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]     data_in,
    input  logic [$clog2(MAX_TAPS_LOG2+1)-1:0] taps_log2,
    output logic                             ready,
    output logic                             out_valid,
    output logic [NUM_CH*DATA_WIDTH-1:0]     lp_out,
    output logic [NUM_CH*DATA_WIDTH-1:0]     hp_out,
    output logic [NUM_CH*DATA_WIDTH-1:0]     ref_out,
    output logic                             overrun
);

    localparam int C_TAPS_W = $clog2(MAX_TAPS_LOG2 + 1);
    localparam int C_DEPTH  = NUM_CH << MAX_TAPS_LOG2;
    localparam int C_ADDR_W = $clog2(C_DEPTH);
    localparam int C_CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int C_ACC_W  = DATA_WIDTH + MAX_TAPS_LOG2;
    localparam logic [MAX_TAPS_LOG2-1:0] C_PTR_ONE = MAX_TAPS_LOG2'(1);

    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_RD_OLD, S_RD_MID, S_WAIT, S_UPD, S_DONE
    } state_t;

    state_t                          r_state, w_state_next;
    logic [C_ADDR_W-1:0]             r_clr_addr;
    logic [C_TAPS_W-1:0]             r_taps;
    logic [MAX_TAPS_LOG2-1:0]        r_ptr;
    logic [C_CH_W-1:0]               r_ch;
    logic [NUM_CH*DATA_WIDTH-1:0]    r_frame;
    logic signed [DATA_WIDTH-1:0]    r_old, r_mid, r_rdata;
    logic signed [C_ACC_W-1:0]       r_acc [NUM_CH];
    logic [NUM_CH*DATA_WIDTH-1:0]    r_lp_stg, r_hp_stg, r_ref_stg;
    logic signed [DATA_WIDTH-1:0]    r_mem [C_DEPTH];

    logic [C_TAPS_W-1:0]             w_taps_hi, w_taps_clamp;
    logic                            w_taps_ok, w_last_ch, w_clr_last;
    logic [MAX_TAPS_LOG2-1:0]        w_mask, w_half, w_mid_off;
    logic [C_ADDR_W-1:0]             w_base, w_old_addr, w_mid_addr, w_raddr, w_waddr;
    logic                            w_we;
    logic signed [DATA_WIDTH-1:0]    w_new, w_wdata, w_lp, w_hp;
    logic signed [C_ACC_W-1:0]       w_acc_next, w_lp_wide;
    logic signed [DATA_WIDTH:0]      w_hp_wide;
    logic                            w_unused;

    // Window exponent is forced into 1..MAX so the reference delay N/2 is never zero
    generate
        if (((1 << C_TAPS_W) - 1) > MAX_TAPS_LOG2) begin : g_clamp_hi
            assign w_taps_hi = (taps_log2 > C_TAPS_W'(MAX_TAPS_LOG2)) ?
                               C_TAPS_W'(MAX_TAPS_LOG2) : taps_log2;
        end else begin : g_no_clamp_hi
            assign w_taps_hi = taps_log2;
        end
    endgenerate

    assign w_taps_clamp = (w_taps_hi == '0) ? C_TAPS_W'(1) : w_taps_hi;
    assign w_taps_ok    = (w_taps_clamp == r_taps);
    assign ready        = (r_state == S_IDLE) && w_taps_ok;
    assign w_last_ch    = (r_ch == C_CH_W'(NUM_CH - 1));
    assign w_clr_last   = (r_clr_addr == C_ADDR_W'(C_DEPTH - 1));

    assign w_mask     = ~({MAX_TAPS_LOG2{1'b1}} << r_taps);
    assign w_half     = C_PTR_ONE << (r_taps - C_TAPS_W'(1));
    assign w_mid_off  = (r_ptr - w_half) & w_mask;
    assign w_base     = C_ADDR_W'(r_ch) << MAX_TAPS_LOG2;
    assign w_old_addr = w_base | C_ADDR_W'(r_ptr);
    assign w_mid_addr = w_base | C_ADDR_W'(w_mid_off);

    assign w_new   = $signed(r_frame[r_ch*DATA_WIDTH +: DATA_WIDTH]);
    assign w_raddr = (r_state == S_RD_OLD) ? w_old_addr : w_mid_addr;
    assign w_we    = (r_state == S_CLEAR) || (r_state == S_UPD);
    assign w_waddr = (r_state == S_CLEAR) ? r_clr_addr : w_old_addr;
    assign w_wdata = (r_state == S_UPD) ? w_new : '0;

    assign w_acc_next = r_acc[r_ch]
                      - {{MAX_TAPS_LOG2{r_old[DATA_WIDTH-1]}}, r_old}
                      + {{MAX_TAPS_LOG2{w_new[DATA_WIDTH-1]}}, w_new};
    assign w_lp_wide  = w_acc_next >>> r_taps;
    assign w_lp       = w_lp_wide[DATA_WIDTH-1:0];
    assign w_hp_wide  = {r_mid[DATA_WIDTH-1], r_mid} - {w_lp[DATA_WIDTH-1], w_lp};
    assign w_unused   = ^w_lp_wide[C_ACC_W-1:DATA_WIDTH];

    always_comb begin
        w_hp = w_hp_wide[DATA_WIDTH-1:0];
        if (w_hp_wide[DATA_WIDTH] != w_hp_wide[DATA_WIDTH-1])
            w_hp = w_hp_wide[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                         : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end

    // Shared ring buffer with one-cycle synchronous read
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
        r_rdata <= r_mem[w_raddr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_CLEAR;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_CLEAR:  if (w_clr_last) w_state_next = S_IDLE;
            S_IDLE: begin
                if (!w_taps_ok)        w_state_next = S_CLEAR;
                else if (sample_valid) w_state_next = S_RD_OLD;
            end
            S_RD_OLD: w_state_next = S_RD_MID;
            S_RD_MID: w_state_next = S_WAIT;
            S_WAIT:   w_state_next = S_UPD;
            S_UPD:    w_state_next = w_last_ch ? S_DONE : S_RD_OLD;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_addr <= '0;
            r_taps     <= C_TAPS_W'(1);
            r_ptr      <= '0;
            r_ch       <= '0;
            r_frame    <= '0;
            r_old      <= '0;
            r_mid      <= '0;
            for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
            r_lp_stg   <= '0;
            r_hp_stg   <= '0;
            r_ref_stg  <= '0;
            lp_out     <= '0;
            hp_out     <= '0;
            ref_out    <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            overrun   <= sample_valid && !ready;
            case (r_state)
                S_CLEAR: begin
                    r_clr_addr <= r_clr_addr + C_ADDR_W'(1);
                    if (w_clr_last) begin
                        r_clr_addr <= '0;
                        r_ptr      <= '0;
                        r_taps     <= w_taps_clamp;
                        for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
                    end
                end
                S_IDLE: begin
                    if (w_taps_ok && sample_valid) begin
                        r_frame <= data_in;
                        r_ch    <= '0;
                    end
                end
                S_RD_MID: r_old <= r_rdata;
                S_WAIT:   r_mid <= r_rdata;
                S_UPD: begin
                    r_acc[r_ch] <= w_acc_next;
                    r_lp_stg[r_ch*DATA_WIDTH +: DATA_WIDTH]  <= w_lp;
                    r_hp_stg[r_ch*DATA_WIDTH +: DATA_WIDTH]  <= w_hp;
                    r_ref_stg[r_ch*DATA_WIDTH +: DATA_WIDTH] <= r_mid;
                    if (!w_last_ch) r_ch <= r_ch + C_CH_W'(1);
                end
                S_DONE: begin
                    lp_out    <= r_lp_stg;
                    hp_out    <= r_hp_stg;
                    ref_out   <= r_ref_stg;
                    out_valid <= 1'b1;
                    r_ptr     <= (r_ptr + C_PTR_ONE) & w_mask;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
